// File: rtl/phys_freelist.sv
// Physical-register free list for a 2-wide rename stage.
// It is a circular buffer of free physical names:
// - head: next name to hand out.
// - tail: next slot to receive a reclaimed name.
// - chead: committed head; a flush rewinds head to it.
//
// Handshake: freelist_rdy[k] is the valid for the name on next_free[k], and
// freelist_en[k] is the consumer's take. Decode may raise freelist_en[k] only
// while freelist_rdy[k] is high. Slot1 alone also needs freelist_rdy[1]. A
// take that is not covered by enough free names is refused and latches err.
// Retirement has no back-pressure: every retire_en bit is taken the cycle it
// is seen. A retire that would overfill the list is refused and latches err.
module phys_freelist #(
  parameter int NUM_PHYS = 32,
  parameter int NUM_ARCH = 16,
  parameter int PW       = $clog2(NUM_PHYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         freelist_en,
  output logic [1:0]         freelist_rdy,
  output logic [1:0][PW-1:0] next_free,
  input  logic [1:0]         retire_en,
  input  logic [1:0][PW-1:0] retire_stale,
  input  logic               flush,
  output logic [PW:0]        free_cnt,
  output logic               err
);

  localparam int          NFREE     = NUM_PHYS - NUM_ARCH;
  localparam logic [PW:0] ONE       = (PW+1)'(1);
  localparam logic [PW:0] TWO       = (PW+1)'(2);
  localparam logic [PW+1:0] NFREE_W = (PW+2)'(NFREE);

  logic [PW-1:0] mem [NUM_PHYS];
  logic [PW:0]   head, tail, chead;
  logic          err_q;

  logic [PW-1:0] head_idx, head1_idx, tail_idx, tail1_idx;
  logic [PW:0]   alloc_need, alloc_adv, ret_n;
  logic          alloc_req, alloc_ok, alloc_err;
  logic          ret_ok, ret_err;
  logic [PW:0]   chead_nxt, tail_nxt;

  assign head_idx  = head[PW-1:0];
  assign head1_idx = head_idx + PW'(1);
  assign tail_idx  = tail[PW-1:0];
  assign tail1_idx = tail_idx + PW'(1);

  // Outputs come straight from registered state; retired names never bypass.
  assign free_cnt        = tail - head;
  assign next_free[0]    = mem[head_idx];
  assign next_free[1]    = mem[head1_idx];
  assign freelist_rdy[0] = (free_cnt >= ONE);
  assign freelist_rdy[1] = (free_cnt >= TWO);
  assign err             = err_q;

  // Decode request sizing and retire/alloc legality.
  // Slot1 alone still needs two names, because it consumes mem[head+1].
  always_comb begin
    alloc_need = '0;
    alloc_adv  = '0;
    case (freelist_en)
      2'b01:   begin alloc_need = ONE; alloc_adv = ONE; end
      2'b10:   begin alloc_need = TWO; alloc_adv = ONE; end
      2'b11:   begin alloc_need = TWO; alloc_adv = TWO; end
      default: begin alloc_need = '0;  alloc_adv = '0;  end
    endcase
    alloc_req = !flush && (freelist_en != 2'b00);
    alloc_ok  = alloc_req && (alloc_need <= free_cnt);
    alloc_err = alloc_req && (alloc_need > free_cnt);

    ret_n   = (PW+1)'(retire_en[0]) + (PW+1)'(retire_en[1]);
    // Retires only commit names already handed out, so the list never
    // legitimately grows past NFREE. Same-cycle allocation cannot matter here.
    ret_ok  = (ret_n != '0) && (({1'b0, free_cnt} + {1'b0, ret_n}) <= NFREE_W);
    ret_err = (ret_n != '0) && !ret_ok;

    chead_nxt = ret_ok ? chead + ret_n : chead;
    tail_nxt  = ret_ok ? tail + ret_n : tail;
  end

  // Pointer, storage and sticky error update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        mem[i] <= (i < NFREE) ? PW'(NUM_ARCH + i) : '0;
      end
      head  <= '0;
      chead <= '0;
      tail  <= (PW+1)'(NFREE);
      err_q <= 1'b0;
    end else begin
      // Slot1-only take: swap so the allocated name sits at the consumed
      // index, keeping flush rewind exact. Both indices lie below tail.
      if (alloc_ok && freelist_en == 2'b10) begin
        mem[head_idx]  <= mem[head1_idx];
        mem[head1_idx] <= mem[head_idx];
      end
      // Compacted in-order writes of reclaimed names, at or beyond tail.
      if (ret_ok) begin
        case (retire_en)
          2'b01:   mem[tail_idx] <= retire_stale[0];
          2'b10:   mem[tail_idx] <= retire_stale[1];
          2'b11:   begin
                     mem[tail_idx]  <= retire_stale[0];
                     mem[tail1_idx] <= retire_stale[1];
                   end
          default: ;
        endcase
      end
      tail  <= tail_nxt;
      chead <= chead_nxt;
      if (flush) begin
        head <= chead_nxt;
      end else if (alloc_ok) begin
        head <= head + alloc_adv;
      end
      if (alloc_err || ret_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_freelist.sv
// Testbench for phys_freelist: directed scenarios plus a random
// allocate/retire run compared against a queue model of the free list.
module tb_phys_freelist;

  localparam int PW = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         freelist_en;
  logic [1:0]         freelist_rdy;
  logic [1:0][PW-1:0] next_free;
  logic [1:0]         retire_en;
  logic [1:0][PW-1:0] retire_stale;
  logic               flush;
  logic [PW:0]        free_cnt;
  logic               err;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] fl_q[$];

  phys_freelist dut (
    .clk          (clk),
    .rst          (rst),
    .freelist_en  (freelist_en),
    .freelist_rdy (freelist_rdy),
    .next_free    (next_free),
    .retire_en    (retire_en),
    .retire_stale (retire_stale),
    .flush        (flush),
    .free_cnt     (free_cnt),
    .err          (err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freelist_en  = 2'b00;
    retire_en    = 2'b00;
    retire_stale = '0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [PW-1:0] e;
    do_reset();
    exp_q.push_back(5'd16);
    exp_q.push_back(5'd17);
    checks++; if (free_cnt !== 6'd16) begin errors++; $display("FAIL reset_cnt got %0d exp 16", free_cnt); end
    checks++; if (freelist_rdy !== 2'b11) begin errors++; $display("FAIL reset_rdy got %b exp 11", freelist_rdy); end
    e = exp_q.pop_front();
    checks++; if (next_free[0] !== e) begin errors++; $display("FAIL reset_nf0 got %0d exp %0d", next_free[0], e); end
    e = exp_q.pop_front();
    checks++; if (next_free[1] !== e) begin errors++; $display("FAIL reset_nf1 got %0d exp %0d", next_free[1], e); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_fill();
    logic [PW-1:0] e;
    do_reset();
    for (int n = 16; n < 32; n++) exp_q.push_back(PW'(n));
    for (int c = 0; c < 8; c++) begin
      freelist_en = 2'b11;
      checks++; if (freelist_rdy !== 2'b11) begin errors++; $display("FAIL fill_rdy cycle %0d got %b exp 11", c, freelist_rdy); end
      e = exp_q.pop_front();
      checks++; if (next_free[0] !== e) begin errors++; $display("FAIL fill_nf0 got %0d exp %0d", next_free[0], e); end
      e = exp_q.pop_front();
      checks++; if (next_free[1] !== e) begin errors++; $display("FAIL fill_nf1 got %0d exp %0d", next_free[1], e); end
      step();
    end
    freelist_en = 2'b00;
    checks++; if (free_cnt !== 6'd0) begin errors++; $display("FAIL fill_cnt got %0d exp 0", free_cnt); end
    checks++; if (freelist_rdy !== 2'b00) begin errors++; $display("FAIL fill_rdy_empty got %b exp 00", freelist_rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err got %b exp 0", err); end
    freelist_en = 2'b11;
    step();
    freelist_en = 2'b00;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b exp 1", err); end
    checks++; if (free_cnt !== 6'd0) begin errors++; $display("FAIL underflow_cnt got %0d exp 0", free_cnt); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_slot1_only();
    logic [PW-1:0] e;
    do_reset();
    exp_q.push_back(5'd17);
    exp_q.push_back(5'd16);
    exp_q.push_back(5'd18);
    freelist_en = 2'b10;
    e = exp_q.pop_front();
    checks++; if (next_free[1] !== e) begin errors++; $display("FAIL slot1_take got %0d exp %0d", next_free[1], e); end
    step();
    freelist_en = 2'b00;
    e = exp_q.pop_front();
    checks++; if (next_free[0] !== e) begin errors++; $display("FAIL slot1_nf0 got %0d exp %0d", next_free[0], e); end
    e = exp_q.pop_front();
    checks++; if (next_free[1] !== e) begin errors++; $display("FAIL slot1_nf1 got %0d exp %0d", next_free[1], e); end
    checks++; if (free_cnt !== 6'd15) begin errors++; $display("FAIL slot1_cnt got %0d exp 15", free_cnt); end
    // Flush after the swap restores the original head with 16 free.
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (free_cnt !== 6'd16) begin errors++; $display("FAIL slot1_flush_cnt got %0d exp 16", free_cnt); end
    checks++; if (next_free[1] !== 5'd16) begin errors++; $display("FAIL slot1_flush_nf1 got %0d exp 16", next_free[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    freelist_en = 2'b11;
    step();
    step();
    freelist_en = 2'b00;
    checks++; if (free_cnt !== 6'd12) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 12", free_cnt); end
    flush = 1'b1;
    freelist_en = 2'b11;
    step();
    flush = 1'b0;
    freelist_en = 2'b00;
    checks++; if (free_cnt !== 6'd16) begin errors++; $display("FAIL flush_cnt got %0d exp 16", free_cnt); end
    checks++; if (next_free[0] !== 5'd16 || next_free[1] !== 5'd17) begin
      errors++; $display("FAIL flush_nf got {%0d,%0d} exp {17,16}", next_free[1], next_free[0]);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", err); end
  endtask

  task automatic test_retire_flush();
    logic [PW-1:0] e;
    do_reset();
    freelist_en = 2'b11;
    step();
    step();
    freelist_en     = 2'b11;
    retire_en       = 2'b11;
    retire_stale[0] = 5'd5;
    retire_stale[1] = 5'd3;
    flush           = 1'b1;
    step();
    idle_inputs();
    checks++; if (free_cnt !== 6'd16) begin errors++; $display("FAIL rf_cnt got %0d exp 16", free_cnt); end
    checks++; if (next_free[0] !== 5'd18) begin errors++; $display("FAIL rf_nf0 got %0d exp 18", next_free[0]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rf_err got %b exp 0", err); end
    for (int n = 18; n < 32; n++) exp_q.push_back(PW'(n));
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd3);
    for (int c = 0; c < 16; c++) begin
      freelist_en = 2'b01;
      e = exp_q.pop_front();
      checks++; if (next_free[0] !== e) begin errors++; $display("FAIL rf_seq %0d got %0d exp %0d", c, next_free[0], e); end
      step();
    end
    freelist_en = 2'b00;
    checks++; if (free_cnt !== 6'd0) begin errors++; $display("FAIL rf_drain_cnt got %0d exp 0", free_cnt); end
  endtask

  task automatic test_retire_overflow();
    do_reset();
    retire_en       = 2'b01;
    retire_stale[0] = 5'd7;
    step();
    idle_inputs();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err); end
    checks++; if (free_cnt !== 6'd16) begin errors++; $display("FAIL ovf_cnt got %0d exp 16", free_cnt); end
    checks++; if (next_free[0] !== 5'd16) begin errors++; $display("FAIL ovf_nf0 got %0d exp 16", next_free[0]); end
  endtask

  // Random legal allocate/retire traffic against a queue model.
  task automatic test_back_to_back();
    int inflight;
    int need;
    int r;
    logic [1:0] en;
    logic [1:0] ren;
    logic [PW-1:0] s0, s1;
    do_reset();
    fl_q.delete();
    for (int n = 16; n < 32; n++) fl_q.push_back(PW'(n));
    inflight = 0;
    for (int c = 0; c < 200; c++) begin
      checks++; if (free_cnt !== (PW+1)'(fl_q.size())) begin errors++; $display("FAIL b2b_cnt cycle %0d got %0d exp %0d", c, free_cnt, fl_q.size()); end
      checks++; if (freelist_rdy !== {fl_q.size() >= 2, fl_q.size() >= 1}) begin errors++; $display("FAIL b2b_rdy cycle %0d got %b size %0d", c, freelist_rdy, fl_q.size()); end
      if (fl_q.size() >= 1) begin
        checks++; if (next_free[0] !== fl_q[0]) begin errors++; $display("FAIL b2b_nf0 cycle %0d got %0d exp %0d", c, next_free[0], fl_q[0]); end
      end
      if (fl_q.size() >= 2) begin
        checks++; if (next_free[1] !== fl_q[1]) begin errors++; $display("FAIL b2b_nf1 cycle %0d got %0d exp %0d", c, next_free[1], fl_q[1]); end
      end
      r = $urandom_range(0, (inflight < 2) ? inflight : 2);
      en = 2'($urandom_range(0, 3));
      need = (en == 2'b00) ? 0 : (en == 2'b01) ? 1 : 2;
      if (need > fl_q.size()) en = 2'b00;
      case (en)
        2'b01: begin void'(fl_q.pop_front()); inflight += 1; end
        2'b10: begin fl_q.delete(1); inflight += 1; end
        2'b11: begin void'(fl_q.pop_front()); void'(fl_q.pop_front()); inflight += 2; end
        default: ;
      endcase
      s0 = PW'($urandom_range(0, 31));
      s1 = PW'($urandom_range(0, 31));
      ren = (r == 2) ? 2'b11 : (r == 1) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00;
      if (ren[0]) fl_q.push_back(s0);
      if (ren[1]) fl_q.push_back(s1);
      inflight -= r;
      freelist_en     = en;
      retire_en       = ren;
      retire_stale[0] = s0;
      retire_stale[1] = s1;
      step();
    end
    idle_inputs();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_slot1_only();
    test_flush();
    test_retire_flush();
    test_retire_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
